// File: rtl/instruction_fetch.sv
// Fetch stage: loadable instruction memory plus PC, issuing one opcode per
// valid/ready handshake until a HALT opcode or an abort.
module instruction_fetch #(
  parameter int          ADDR_W  = 8,
  parameter int          DATA_W  = 16,
  parameter logic [2:0]  HALT_OP = 3'b111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              abort,
  output logic [DATA_W-1:0] opcode,
  output logic              opcode_valid,
  input  logic              opcode_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic [15:0]       issue_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_rd;
  logic              slot_free;
  logic              is_halt;

  assign mem_rd    = mem[pc];
  assign slot_free = !opcode_valid || opcode_ready;
  assign is_halt   = (mem_rd[DATA_W-1 -: 3] == HALT_OP);

  // NOTE: the program array carries no reset; software loads it before start,
  // and leaving it out of the reset keeps it a plain register file.
  always_ff @(posedge clk) begin
    if (prog_we && state != S_RUN) mem[prog_addr] <= prog_data;
  end

  // NOTE: busy/done are registers updated alongside state, so they are
  // glitch-free and change on the same edge as the state they report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      pc           <= '0;
      opcode       <= '0;
      opcode_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      issue_count  <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (state == S_DONE && abort) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end else if (start) begin
            state        <= S_RUN;
            busy         <= 1'b1;
            done         <= 1'b0;
            pc           <= start_addr;
            issue_count  <= '0;
            opcode_valid <= 1'b0;
          end
        end
        S_RUN: begin
          if (abort) begin
            // Abort wins over fetch and HALT; the pending opcode is dropped.
            state        <= S_IDLE;
            busy         <= 1'b0;
            opcode_valid <= 1'b0;
          end else if (slot_free) begin
            if (is_halt) begin
              // pc stays on the HALT word; HALT itself is never issued.
              state        <= S_DONE;
              busy         <= 1'b0;
              done         <= 1'b1;
              opcode_valid <= 1'b0;
            end else begin
              opcode       <= mem_rd;
              opcode_valid <= 1'b1;
              pc           <= pc + ADDR_W'(1);
              if (issue_count != 16'hFFFF) issue_count <= issue_count + 16'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Upstream fetch stage for the 16-bit processor. Holds the loadable instruction memory and a program counter.
- Issues one 16-bit opcode per handshake to the execute stage through a valid/ready output register.
- Stops on a HALT opcode or an abort.
- Execute stage with no backpressure ties opcode_ready high.

Parameters:
- ADDR_W, 8: PC / memory address width; depth = 2**ADDR_W.
- DATA_W, 16: instruction width.
- HALT_OP, 3'b111: value of opcode[DATA_W-1:DATA_W-3] that marks HALT.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- prog_we  in  1  program-write strobe.
- prog_addr  in  ADDR_W  program-write address.
- prog_data  in  DATA_W  program-write data.
- start  in  1  begin fetching (pulse).
- start_addr  in  ADDR_W  first PC on start.
- abort  in  1  stop fetching immediately.
- opcode  out  DATA_W  issued instruction (registered).
- opcode_valid  out  1  opcode holds an unconsumed instruction.
- opcode_ready  in  1  downstream accepts opcode this cycle.
- pc  out  ADDR_W  address of next instruction to fetch.
- busy  out  1  state == RUN.
- done  out  1  state == DONE (HALT reached).
- issue_count  out  16  instructions issued since last start, saturating.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: state=IDLE, pc=0, opcode=0, opcode_valid=0, busy=0, done=0, issue_count=0. Memory contents are not reset.
- Memory: 2**ADDR_W x DATA_W register array.
  - Combinational read at pc.
  - Synchronous write at clk edge when prog_we=1 and state is IDLE or DONE.
  - prog_we is ignored in RUN.
- Handshake: a transfer occurs in any cycle with opcode_valid && opcode_ready.
  - opcode and opcode_valid stay stable while valid && !ready.
- "Slot free" = !opcode_valid || opcode_ready.
- States:
  - IDLE: start=1 -> RUN next edge; pc<=start_addr, issue_count<=0, opcode_valid<=0.
  - RUN, slot free, mem[pc] top 3 bits != HALT_OP: opcode<=mem[pc], opcode_valid<=1, pc<=pc+1, issue_count+=1 (saturate at 16'hFFFF).
  - RUN, slot free, mem[pc] is HALT: opcode_valid<=0, pc unchanged (points at HALT), -> DONE. HALT is never issued.
  - RUN, slot not free: hold everything.
  - RUN, abort=1: -> IDLE, opcode_valid<=0; any pending opcode is dropped. Abort has priority over fetch/HALT.
  - DONE: done=1. start=1 -> RUN exactly as from IDLE. abort=1 -> IDLE.
- Latency: first opcode_valid appears 2 edges after the start edge (start edge -> RUN, next edge issues). Sustained throughput is 1 opcode/cycle with ready held high.
- PC wrap: pc at 2**ADDR_W-1 increments to 0 and fetch continues; no flag.
- start while in RUN: ignored.
- Simultaneous prog_we and start in IDLE: write completes at the same edge. The first fetch, a cycle later, sees the new data.
- Reset asserted mid-RUN: immediate return to reset values; the pending opcode is lost.
- Write and fetch of the same address cannot coincide, because writes are blocked in RUN.

Test Plan:
- Load mem[0..3]={16'h0140,16'h2081,16'h4081,16'hE000}, start_addr=0, ready=1 -> opcodes 0140, 2081, 4081 on 3 consecutive cycles; then valid=0, done=1, pc=3, issue_count=3.
- Same program, ready=0 for 4 cycles after first valid -> opcode stays 0140 with valid=1 and pc=1; after ready=1, remaining order unchanged with no duplicates or drops.
- mem[255]=16'h0010, mem[0]=16'h0020, mem[1]=HALT, start_addr=255 -> issues 0010 then 0020; pc wraps 255->0->1; done=1.
- abort during RUN with valid=1, ready=0 -> next edge valid=0, busy=0, state IDLE. A new start at start_addr=2 resumes from 2 with issue_count cleared.
- prog_we=1 in RUN to an address not yet fetched -> memory unchanged; the old value is issued. The same write in DONE takes effect and a restart fetches the new value.
- rst_n low asynchronously mid-RUN (between edges) -> outputs drop to reset values immediately. After release, memory retains its program and a restart reproduces the first scenario.
